// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// Holds the MDU FSM encoding and common constants.
package pipe_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } mdu_st_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs from ID/EX and pipeline control outputs.
// master = pipeline side, slave = controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_use_hilo;
  logic             idex_memrd;
  logic [4:0]       idex_rt;
  logic             ex_br_taken;
  logic             id_jump;
  logic             mdu_start;
  logic             pc_stay;
  logic             ifid_stay;
  logic             ifid_null;
  logic             idex_null;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output id_use_hilo, idex_memrd, idex_rt,
    output ex_br_taken, id_jump, mdu_start,
    input  pc_stay, ifid_stay, ifid_null,
    input  idex_null, mdu_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_use_hilo, idex_memrd, idex_rt,
    input  ex_br_taken, id_jump, mdu_start,
    output pc_stay, ifid_stay, ifid_null,
    output idex_null, mdu_busy,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / HI-LO stall, branch/jump flush and MDU wait control.
// Control outputs are combinational from inputs and FSM state.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
);

  localparam int MW = $clog2(MDU_LAT + 1);
  localparam logic [MW-1:0] CNT_LD = MW'(MDU_LAT - 1);

  mdu_st_t       state;
  logic [MW-1:0] mdu_cnt;

  logic busy, lu, hl, stl;
  logic sel_br, sel_st, sel_jp;
  logic pc_stay, ifid_stay, ifid_null, idex_null;

  assign busy = (state == ST_MDU_WAIT) && !reset;

  assign lu = hz.idex_memrd && (hz.idex_rt != REG_ZERO) &&
              ((hz.id_use_rs && (hz.id_rs == hz.idex_rt)) ||
               (hz.id_use_rt && (hz.id_rt == hz.idex_rt)));
  assign hl  = hz.id_use_hilo && busy;
  assign stl = lu || hl;

  // one-hot selects so the decoder sees exclusive cases
  assign sel_br = hz.ex_br_taken;
  assign sel_st = stl && !hz.ex_br_taken;
  assign sel_jp = hz.id_jump && !stl && !hz.ex_br_taken;

  always_comb begin
    pc_stay   = 1'b0;
    ifid_stay = 1'b0;
    ifid_null = 1'b0;
    idex_null = 1'b0;
    if (reset) begin
      ifid_null = 1'b1;
      idex_null = 1'b1;
    end else begin
      unique case (1'b1)
        sel_br: begin
          ifid_null = 1'b1;
          idex_null = 1'b1;
        end
        sel_st: begin
          pc_stay   = 1'b1;
          ifid_stay = 1'b1;
          idex_null = 1'b1;
        end
        sel_jp:  ifid_null = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      mdu_cnt <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (hz.mdu_start) begin
            state   <= ST_MDU_WAIT;
            mdu_cnt <= CNT_LD;
          end
        end
        ST_MDU_WAIT: begin
          if (hz.mdu_start) begin
            mdu_cnt <= CNT_LD;
          end else if (mdu_cnt == MW'(1)) begin
            state   <= ST_RUN;
            mdu_cnt <= '0;
          end else begin
            mdu_cnt <= mdu_cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_RUN;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.pc_stay   = pc_stay;
  assign hz.ifid_stay = ifid_stay;
  assign hz.ifid_null = ifid_null;
  assign hz.idex_null = idex_null;
  assign hz.mdu_busy  = busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stay),
    .cnt   (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_null && !reset),
    .cnt   (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed test of hazard_stall_ctrl, MDU_LAT=4, CNT_W=4.
// ctrl vector order: {pc_stay, ifid_stay, ifid_null, idex_null}.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(4)) hif ();

  hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ctrl();
    return {12'd0, hif.pc_stay, hif.ifid_stay,
            hif.ifid_null, hif.idex_null};
  endfunction

  task automatic clr();
    hif.id_rs       = 5'd0;
    hif.id_rt       = 5'd0;
    hif.id_use_rs   = 1'b0;
    hif.id_use_rt   = 1'b0;
    hif.id_use_hilo = 1'b0;
    hif.idex_memrd  = 1'b0;
    hif.idex_rt     = 5'd0;
    hif.ex_br_taken = 1'b0;
    hif.id_jump     = 1'b0;
    hif.mdu_start   = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lu_rs5();
    hif.idex_memrd = 1'b1;
    hif.idex_rt    = 5'd5;
    hif.id_rs      = 5'd5;
    hif.id_use_rs  = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    cyc();
    #2;
    chk("rst_ctrl", ctrl(), 16'h3);
    chk("rst_busy", 16'(hif.mdu_busy), 16'h0);
    cyc();
    chk("rst_stall", 16'(hif.stall_cnt), 16'h0);
    chk("rst_flush", 16'(hif.flush_cnt), 16'h0);
    reset = 1'b0;

    // load-use on rs
    cyc();
    lu_rs5();
    #2;
    chk("lu_rs", ctrl(), 16'hd);
    cyc();
    clr();
    #2;
    chk("lu_rel", ctrl(), 16'h0);
    chk("lu_scnt", 16'(hif.stall_cnt), 16'h1);

    // load to r0 never stalls
    cyc();
    hif.idex_memrd = 1'b1;
    hif.id_use_rs  = 1'b1;
    #2;
    chk("lu_r0", ctrl(), 16'h0);

    // load-use on rt
    cyc();
    clr();
    hif.idex_memrd = 1'b1;
    hif.idex_rt    = 5'd7;
    hif.id_rt      = 5'd7;
    hif.id_use_rt  = 1'b1;
    hif.id_rs      = 5'd7;
    #2;
    chk("lu_rt", ctrl(), 16'hd);

    // rt match but rt not used
    cyc();
    hif.id_use_rt = 1'b0;
    #2;
    chk("lu_nouse", ctrl(), 16'h0);
    chk("scnt2", 16'(hif.stall_cnt), 16'h2);

    // jump only
    cyc();
    clr();
    hif.id_jump = 1'b1;
    #2;
    chk("jump", ctrl(), 16'h2);

    // stall beats jump
    cyc();
    lu_rs5();
    #2;
    chk("st_jump", ctrl(), 16'hd);
    chk("fcnt1", 16'(hif.flush_cnt), 16'h1);

    // branch beats load-use stall
    cyc();
    hif.id_jump     = 1'b0;
    hif.ex_br_taken = 1'b1;
    #2;
    chk("br_lu", ctrl(), 16'h3);
    chk("scnt3", 16'(hif.stall_cnt), 16'h3);
    cyc();
    clr();
    #2;
    chk("br_fcnt", 16'(hif.flush_cnt), 16'h2);
    chk("br_scnt", 16'(hif.stall_cnt), 16'h3);

    // MDU wait: start at t, MFLO from t+1
    hif.mdu_start = 1'b1;
    #1;
    chk("mdu_t", 16'(hif.mdu_busy), 16'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      clr();
      hif.id_use_hilo = 1'b1;
      #2;
      chk($sformatf("mdu_busy%0d", i), 16'(hif.mdu_busy), 16'h1);
      chk($sformatf("mdu_ctl%0d", i), ctrl(), 16'hd);
    end
    cyc();
    #2;
    chk("mdu_done", 16'(hif.mdu_busy), 16'h0);
    chk("mdu_rel", ctrl(), 16'h0);
    chk("mdu_scnt", 16'(hif.stall_cnt), 16'h6);

    // branch does not cancel MDU op
    clr();
    hif.mdu_start = 1'b1;
    cyc();
    clr();
    hif.ex_br_taken = 1'b1;
    hif.id_use_hilo = 1'b1;
    #2;
    chk("mdu_br", ctrl(), 16'h3);
    cyc();
    clr();
    #2;
    chk("mdu_keep", 16'(hif.mdu_busy), 16'h1);

    // restart in MDU_WAIT extends busy
    hif.mdu_start = 1'b1;
    cyc();
    clr();
    cyc();
    cyc();
    #2;
    chk("mdu_rst3", 16'(hif.mdu_busy), 16'h1);

    // reset mid-wait
    reset = 1'b1;
    hif.id_use_hilo = 1'b1;
    #1;
    chk("rw_busy", 16'(hif.mdu_busy), 16'h0);
    chk("rw_ctrl", ctrl(), 16'h3);
    cyc();
    reset = 1'b0;
    #2;
    chk("rw_busy2", 16'(hif.mdu_busy), 16'h0);
    chk("rw_ctrl2", ctrl(), 16'h0);
    chk("rw_scnt", 16'(hif.stall_cnt), 16'h0);
    chk("rw_fcnt", 16'(hif.flush_cnt), 16'h0);

    // saturation: 16 stall cycles into a 4-bit counter
    clr();
    lu_rs5();
    repeat (15) cyc();
    chk("sat15", 16'(hif.stall_cnt), 16'hf);
    cyc();
    chk("sat16", 16'(hif.stall_cnt), 16'hf);
    clr();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
